// File: rtl/booth_mul_seq_if.sv
// Request/response bundle for the iterative Booth multiplier.
// The master drives the operands and start; the slave returns busy, done and the product.
interface booth_mul_seq_if #(parameter int W = 8);
  logic           start;
  logic           signed_mode;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] m;

  modport master (output start, signed_mode, a, b, input busy, done, m);
  modport slave  (input start, signed_mode, a, b, output busy, done, m);
endinterface

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier: one Booth digit per clock through a single shared adder.
// Operands are extended to W+2 bits, so signed and unsigned modes share one datapath.
module booth_mul_seq #(
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          rst,
  booth_mul_seq_if.slave bus
);
  localparam int N  = W / 2 + 1;
  localparam int XW = W + 2;
  localparam int AW = W + 3;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [XW-1:0]  a_q, a_d;
  logic [AW-1:0]  acc_q, acc_d;
  logic [XW-1:0]  mul_q, mul_d;
  logic           qm1_q, qm1_d;
  logic [2*W-1:0] m_q, m_d;
  logic           done_q, done_d;

  logic [XW-1:0]  a_ext, b_ext;
  logic [2:0]     digit;
  logic [AW-1:0]  sel_x, addend, sum;
  logic           neg;
  logic [AW-1:0]  acc_sh;
  logic [XW-1:0]  mul_sh;

  assign a_ext = {{2{bus.signed_mode & bus.a[W-1]}}, bus.a};
  assign b_ext = {{2{bus.signed_mode & bus.b[W-1]}}, bus.b};
  assign digit = {mul_q[1:0], qm1_q};

  always_comb begin
    sel_x = '0;
    neg   = 1'b0;
    case (digit)
      3'b001, 3'b010: sel_x = {a_q[XW-1], a_q};
      3'b011:         sel_x = {a_q, 1'b0};
      3'b100: begin
        sel_x = {a_q, 1'b0};
        neg   = 1'b1;
      end
      3'b101, 3'b110: begin
        sel_x = {a_q[XW-1], a_q};
        neg   = 1'b1;
      end
      default: ;
    endcase
  end

  // Subtraction reuses the adder: invert the operand and inject the +1 as carry-in.
  assign addend = sel_x ^ {AW{neg}};
  assign sum    = acc_q + addend + {{(AW-1){1'b0}}, neg};
  assign acc_sh = {{2{sum[AW-1]}}, sum[AW-1:2]};
  assign mul_sh = {sum[1:0], mul_q[XW-1:2]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    acc_d   = acc_q;
    mul_d   = mul_q;
    qm1_d   = qm1_q;
    m_d     = m_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = a_ext;
          mul_d   = b_ext;
          acc_d   = '0;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_sh;
        mul_d = mul_sh;
        qm1_d = mul_q[1];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) state_d = DONE;
      end
      DONE: begin
        // Low 2W bits of the {acc, mul} pair after all digits have been shifted out.
        done_d  = 1'b1;
        m_d     = {acc_q[W-3:0], mul_q};
        state_d = IDLE;
        if (bus.start) begin
          a_d     = a_ext;
          mul_d   = b_ext;
          acc_d   = '0;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      acc_q   <= '0;
      mul_q   <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      mul_q   <= mul_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == CALC);
  assign bus.done = done_q;
  assign bus.m    = m_q;
endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed bench for booth_mul_seq at W=8: corner products, latency, back-to-back, ignored start, reset abort.
module tb_booth_mul_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  booth_mul_seq_if #(.W(8)) bus ();
  booth_mul_seq #(.W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic launch(input logic sm, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.signed_mode = sm;
    bus.a           = a;
    bus.b           = b;
    @(posedge clk);
    #1;
  endtask

  // Waits up to 20 edges for done; returns edges counted and busy-high samples seen.
  task automatic wait_done(output logic [15:0] res, output int lat, output int bcnt);
    res  = 16'hxxxx;
    lat  = 20;
    bcnt = int'(bus.busy);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        res = bus.m;
        lat = k;
        break;
      end
      bcnt += int'(bus.busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b0; bus.signed_mode = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.m !== 16'h0) begin
      fails++;
      $display("FAIL reset: busy=%b done=%b m=%h, want 0 0 0000", bus.busy, bus.done, bus.m);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_vectors;
    logic        sm [12] = '{1, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    logic [7:0]  va [12] = '{8'h80, 8'h7F, 8'hFF, 8'hFF, 8'h80, 8'h7F, 8'h00, 8'h80, 8'hFF, 8'h80, 8'h7F, 8'hFF};
    logic [7:0]  vb [12] = '{8'h80, 8'h80, 8'hFF, 8'hFF, 8'h80, 8'h7F, 8'hAB, 8'h01, 8'h01, 8'h7F, 8'h80, 8'h80};
    logic [15:0] ex [12] = '{16'h4000, 16'hC080, 16'hFE01, 16'h0001, 16'h4000, 16'h3F01,
                             16'h0000, 16'hFF80, 16'h00FF, 16'hC080, 16'h3F80, 16'h0080};
    logic [15:0] res;
    int lat, bcnt;
    for (int i = 0; i < 12; i++) begin
      launch(sm[i], va[i], vb[i]);
      bus.start = 1'b0;
      wait_done(res, lat, bcnt);
      tests++;
      if (res !== ex[i]) begin
        fails++;
        $display("FAIL vec%0d product: s=%b %h*%h got %h want %h", i, sm[i], va[i], vb[i], res, ex[i]);
      end
      tests++;
      if (lat != 6 || bcnt != 5) begin
        fails++;
        $display("FAIL vec%0d timing: latency %0d busy %0d, want 6 and 5", i, lat, bcnt);
      end
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (bus.done !== 1'b0 || bus.m !== ex[i]) begin
        fails++;
        $display("FAIL vec%0d hold: done=%b m=%h, want 0 %h", i, bus.done, bus.m, ex[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] r1, r2;
    int l1, l2, b1, b2;
    launch(1'b1, 8'd3, 8'd5);
    bus.a = 8'hF9;
    bus.b = 8'd9;
    wait_done(r1, l1, b1);
    bus.start = 1'b0;
    wait_done(r2, l2, b2);
    tests++;
    if (r1 !== 16'h000F || l1 != 6) begin
      fails++;
      $display("FAIL b2b first: m=%h lat=%0d, want 000f 6", r1, l1);
    end
    tests++;
    if (r2 !== 16'hFFC1 || l2 != 6) begin
      fails++;
      $display("FAIL b2b second: m=%h gap=%0d, want ffc1 6", r2, l2);
    end
  endtask

  task automatic test_ignore_mid;
    logic [15:0] res;
    int lat, bcnt, extra;
    launch(1'b1, 8'd10, 8'd20);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b1; bus.a = 8'd1; bus.b = 8'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(res, lat, bcnt);
    tests++;
    if (res !== 16'h00C8 || lat != 4) begin
      fails++;
      $display("FAIL ignore_mid result: m=%h lat=%0d, want 00c8 4", res, lat);
    end
    extra = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      extra += int'(bus.done) + int'(bus.busy);
    end
    tests++;
    if (extra != 0) begin
      fails++;
      $display("FAIL ignore_mid extra: %0d done/busy samples, want 0", extra);
    end
  endtask

  task automatic test_reset_abort;
    logic [15:0] res;
    int lat, bcnt, extra;
    launch(1'b0, 8'h55, 8'h33);
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.m !== 16'h0) begin
      fails++;
      $display("FAIL abort state: busy=%b done=%b m=%h, want 0 0 0000", bus.busy, bus.done, bus.m);
    end
    extra = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      extra += int'(bus.done);
    end
    tests++;
    if (extra != 0) begin
      fails++;
      $display("FAIL abort done: %0d done pulses, want 0", extra);
    end
    launch(1'b0, 8'h55, 8'h33);
    bus.start = 1'b0;
    wait_done(res, lat, bcnt);
    tests++;
    if (res !== 16'h10EF || lat != 6) begin
      fails++;
      $display("FAIL abort restart: m=%h lat=%0d, want 10ef 6", res, lat);
    end
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_back_to_back;
    test_ignore_mid;
    test_reset_abort;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
